// File: rtl/shortread_scheduler.sv
// shortread_scheduler: queues 10-base short reads and issues them one at a time to the match engine.
// Define SHORTREAD_SCHED_RC_PASS_EN to add the reverse-complement retry pass after a forward miss.
module shortread_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 63
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] read_in,
    input  logic        read_valid,
    output logic        read_ready,
    output logic [19:0] eng_shortread,
    output logic        eng_start,
    input  logic        eng_done,
    input  logic        eng_found,
    input  logic [7:0]  eng_index,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_index,
    output logic [3:0]  res_id,
    output logic [1:0]  res_status,
    output logic        busy
);

    localparam int              PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]     FULL_COUNT = FIFO_DEPTH[PW:0];
    localparam logic [7:0]      WD_LAST    = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT     = 3'd2,
`ifdef SHORTREAD_SCHED_RC_PASS_EN
        S_RC_ISSUE = 3'd3,
        S_RC_WAIT  = 3'd4,
`endif
        S_RESULT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ST_FWD_HIT = 2'b00,
        ST_RC_HIT  = 2'b01,
        ST_MISS    = 2'b10,
        ST_TIMEOUT = 2'b11
    } status_t;

    state_t      state, state_nxt;
    status_t     status_nxt;
    logic [7:0]  index_nxt;
    logic        push, pop, res_load, in_wait, wd_expired;
    logic [23:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic [3:0]  id_ctr, work_id;
    logic [7:0]  wd;

    assign push       = read_valid && read_ready;
    assign read_ready = (count != FULL_COUNT);
    assign busy       = (state != S_IDLE) || (count != '0);
    assign res_valid  = (state == S_RESULT);
    // wd counts completed WAIT cycles, so the TIMEOUT-th WAIT cycle is the last one honoured.
    assign wd_expired = (wd == WD_LAST);

`ifdef SHORTREAD_SCHED_RC_PASS_EN
    logic        rc_load;
    logic [19:0] rc_read;

    assign in_wait = (state == S_WAIT) || (state == S_RC_WAIT);

    always_comb begin
        rc_read = '0;
        for (int i = 0; i < 10; i++) begin
            rc_read[2*i +: 2] = ~eng_shortread[2*(9-i) +: 2];
        end
    end
`else
    assign in_wait = (state == S_WAIT);
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        pop        = 1'b0;
        eng_start  = 1'b0;
        res_load   = 1'b0;
        status_nxt = ST_MISS;
        index_nxt  = 8'hFF;
`ifdef SHORTREAD_SCHED_RC_PASS_EN
        rc_load    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done && eng_found) begin
                    res_load   = 1'b1;
                    status_nxt = ST_FWD_HIT;
                    index_nxt  = eng_index;
                    state_nxt  = S_RESULT;
                end else if (eng_done) begin
`ifdef SHORTREAD_SCHED_RC_PASS_EN
                    rc_load    = 1'b1;
                    state_nxt  = S_RC_ISSUE;
`else
                    res_load   = 1'b1;
                    state_nxt  = S_RESULT;
`endif
                end else if (wd_expired) begin
                    res_load   = 1'b1;
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = S_RESULT;
                end
            end
`ifdef SHORTREAD_SCHED_RC_PASS_EN
            S_RC_ISSUE: begin
                eng_start = 1'b1;
                state_nxt = S_RC_WAIT;
            end
            S_RC_WAIT: begin
                if (eng_done && eng_found) begin
                    res_load   = 1'b1;
                    status_nxt = ST_RC_HIT;
                    index_nxt  = eng_index;
                    state_nxt  = S_RESULT;
                end else if (eng_done) begin
                    res_load   = 1'b1;
                    state_nxt  = S_RESULT;
                end else if (wd_expired) begin
                    res_load   = 1'b1;
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = S_RESULT;
                end
            end
`endif
            S_RESULT: begin
                if (res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: the queue storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {id_ctr, read_in};
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            id_ctr        <= '0;
            work_id       <= '0;
            wd            <= '0;
            eng_shortread <= '0;
            res_index     <= 8'hFF;
            res_id        <= '0;
            res_status    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                id_ctr <= id_ctr + 4'd1;
            end
            if (pop) begin
                rd_ptr                   <= rd_ptr + 1'b1;
                {work_id, eng_shortread} <= fifo_mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (eng_start)    wd <= '0;
            else if (in_wait) wd <= wd + 8'd1;
`ifdef SHORTREAD_SCHED_RC_PASS_EN
            if (rc_load) eng_shortread <= rc_read;
`endif
            if (res_load) begin
                res_index  <= index_nxt;
                res_status <= status_nxt;
                res_id     <= work_id;
            end
        end
    end

endmodule

// File: tb/tb_shortread_scheduler.sv
// Self-checking bench for shortread_scheduler: directed scenarios plus a randomized run,
// each result predicted from the engine responses the bench itself chose.
module tb_shortread_scheduler;

    localparam int         TIMEOUT = 63;
    localparam logic [1:0] ST_FWD  = 2'b00;
    localparam logic [1:0] ST_RC   = 2'b01;
    localparam logic [1:0] ST_MISS = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] read_in;
    logic        read_valid;
    logic        read_ready;
    logic [19:0] eng_shortread;
    logic        eng_start;
    logic        eng_done;
    logic        eng_found;
    logic [7:0]  eng_index;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_index;
    logic [3:0]  res_id;
    logic [1:0]  res_status;
    logic        busy;

    int          vectors     = 0;
    int          miscompares = 0;
    int          start_cnt   = 0;
    logic [19:0] last_rc_sr  = '0;
    logic [19:0] bp_reads [5];

    shortread_scheduler #(.FIFO_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .read_in       (read_in),
        .read_valid    (read_valid),
        .read_ready    (read_ready),
        .eng_shortread (eng_shortread),
        .eng_start     (eng_start),
        .eng_done      (eng_done),
        .eng_found     (eng_found),
        .eng_index     (eng_index),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_index     (res_index),
        .res_id        (res_id),
        .res_status    (res_status),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (eng_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    // Reverse complement from the base-level definition: reverse base order, swap A/T and G/C.
    function automatic logic [19:0] revcomp(input logic [19:0] r);
        logic [1:0]  b [10];
        logic [19:0] o;
        for (int i = 0; i < 10; i++) b[i] = r[19-2*i -: 2];
        o = '0;
        for (int i = 0; i < 10; i++) o[19-2*i -: 2] = 2'd3 - b[9-i];
        return o;
    endfunction

    function automatic int rand_lat();
        case ($urandom_range(0, 4))
            0:       return 0;
            1:       return 1;
            2:       return TIMEOUT;
            default: return int'($urandom_range(2, TIMEOUT - 1));
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        read_valid = 1'b0;
        read_in    = '0;
        eng_done   = 1'b0;
        eng_found  = 1'b0;
        eng_index  = '0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " eng_start"},     32'(eng_start),     32'd0);
        check({tag, " res_valid"},     32'(res_valid),     32'd0);
        check({tag, " busy"},          32'(busy),          32'd0);
        check({tag, " eng_shortread"}, 32'(eng_shortread), 32'd0);
        check({tag, " res_index"},     32'(res_index),     32'hFF);
        check({tag, " res_id"},        32'(res_id),        32'd0);
        check({tag, " res_status"},    32'(res_status),    32'd0);
        check({tag, " read_ready"},    32'(read_ready),    32'd1);
    endtask

    // Offers one read for one cycle; returns on the following negedge.
    task automatic push(input string tag, input logic [19:0] rd);
        check({tag, " read_ready"}, 32'(read_ready), 32'd1);
        read_valid = 1'b1;
        read_in    = rd;
        @(negedge clk);
        read_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int exp_wait);
        int waited = 0;
        while (eng_start !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " eng_start"}, 32'(eng_start), 32'd1);
        if (exp_wait >= 0) check({tag, " issue latency"}, 32'(waited), 32'(exp_wait));
    endtask

    // Called in the eng_start cycle S; returns in S+lat+1 (or S+TIMEOUT+1 when lat is 0).
    task automatic engine_pass(input string tag, input logic [19:0] exp_sr,
                               input int lat, input bit hit, input logic [7:0] idx);
        check({tag, " eng_shortread"}, 32'(eng_shortread), 32'(exp_sr));
        if (lat == 0) begin
            repeat (TIMEOUT) @(negedge clk);
            check({tag, " res_valid before timeout"}, 32'(res_valid), 32'd0);
            @(negedge clk);
        end else begin
            repeat (lat) @(negedge clk);
            check({tag, " eng_shortread held"}, 32'(eng_shortread), 32'(exp_sr));
            eng_done  = 1'b1;
            eng_found = hit;
            eng_index = idx;
            @(negedge clk);
            eng_done  = 1'b0;
            eng_found = 1'b0;
            eng_index = '0;
        end
    endtask

    task automatic take_result(input string tag, input logic [3:0] id, input logic [1:0] st,
                               input logic [7:0] idx, input int stall);
        check({tag, " res_valid"},  32'(res_valid),  32'd1);
        check({tag, " res_id"},     32'(res_id),     32'(id));
        check({tag, " res_status"}, 32'(res_status), 32'(st));
        check({tag, " res_index"},  32'(res_index),  32'(idx));
        for (int k = 0; k < stall; k++) begin
            if (k == 0) begin
                eng_done  = 1'b1;
                eng_found = 1'b1;
                eng_index = 8'($urandom);
            end
            @(negedge clk);
            eng_done  = 1'b0;
            eng_found = 1'b0;
            check({tag, " held res_valid"},  32'(res_valid),  32'd1);
            check({tag, " held res_id"},     32'(res_id),     32'(id));
            check({tag, " held res_status"}, 32'(res_status), 32'(st));
            check({tag, " held res_index"},  32'(res_index),  32'(idx));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, " res_valid after accept"}, 32'(res_valid), 32'd0);
    endtask

    // Plays the engine for one read and predicts the reported result from the chosen responses.
    task automatic serve(input string tag, input logic [19:0] rd, input logic [3:0] id,
                         input int exp_wait, input int lat_f, input bit hit_f, input logic [7:0] idx_f,
                         input int lat_r, input bit hit_r, input logic [7:0] idx_r, input int stall);
        int         s0;
        int         passes;
        logic [1:0] st;
        logic [7:0] idx;
        s0     = start_cnt;
        passes = 1;
        wait_start(tag, exp_wait);
        engine_pass({tag, " fwd"}, rd, lat_f, hit_f, idx_f);
        if (lat_f == 0) begin
            st = ST_TMO;  idx = 8'hFF;
        end else if (hit_f) begin
            st = ST_FWD;  idx = idx_f;
        end else begin
`ifdef SHORTREAD_SCHED_RC_PASS_EN
            check({tag, " rc eng_start"}, 32'(eng_start), 32'd1);
            last_rc_sr = eng_shortread;
            engine_pass({tag, " rc"}, revcomp(rd), lat_r, hit_r, idx_r);
            passes = 2;
            if (lat_r == 0) begin
                st = ST_TMO;  idx = 8'hFF;
            end else if (hit_r) begin
                st = ST_RC;   idx = idx_r;
            end else begin
                st = ST_MISS; idx = 8'hFF;
            end
`else
            st = ST_MISS; idx = 8'hFF;
`endif
        end
        take_result(tag, id, st, idx, stall);
        check({tag, " engine passes"}, 32'(start_cnt - s0), 32'(passes));
    endtask

    initial begin
        logic [19:0] rd;
        int          waited;

        reset      = 1'b1;
        read_valid = 1'b0;
        read_in    = '0;
        eng_done   = 1'b0;
        eng_found  = 1'b0;
        eng_index  = '0;
        res_ready  = 1'b0;
        @(negedge clk);
        do_reset();
        check_reset_values("reset");

        // Forward hit: start two cycles after accept, one pass, status 00.
        push("fwd", 20'h4784A);
        serve("fwd", 20'h4784A, 4'd0, 1, 1, 1'b1, 8'd20, 0, 1'b0, 8'd0, 2);
        check("fwd idle busy", 32'(busy), 32'd0);

        // Forward miss: retried on the reverse strand when enabled, else a plain miss.
        push("rc", 20'h4784A);
        serve("rc", 20'h4784A, 4'd1, 1, 2, 1'b0, 8'd0, 1, 1'b1, 8'd7, 1);
`ifdef SHORTREAD_SCHED_RC_PASS_EN
        check("rc presented strand", 32'(last_rc_sr), 32'h5ED2E);
`endif

        rd = 20'($urandom);
        push("timeout", rd);
        serve("timeout", rd, 4'd2, 1, 0, 1'b0, 8'd0, 0, 1'b0, 8'd0, 0);

        rd = 20'($urandom);
        push("last cycle hit", rd);
        serve("last cycle hit", rd, 4'd3, 1, TIMEOUT, 1'b1, 8'd200, 0, 1'b0, 8'd0, 1);

        rd = 20'($urandom);
        push("double miss", rd);
        serve("double miss", rd, 4'd4, 1, 3, 1'b0, 8'd0, 4, 1'b0, 8'd0, 0);

        rd = 20'($urandom);
        push("rc timeout", rd);
        serve("rc timeout", rd, 4'd5, 1, 1, 1'b0, 8'd0, 0, 1'b0, 8'd0, 1);
        check("directed idle busy", 32'(busy), 32'd0);

        // Backpressure: one read in flight and four queued fill the FIFO.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bp_reads[i] = 20'($urandom);
            push($sformatf("bp push%0d", i), bp_reads[i]);
        end
        read_valid = 1'b1;
        read_in    = 20'($urandom);
        check("bp full", 32'(read_ready), 32'd0);
        @(negedge clk);
        check("bp full held", 32'(read_ready), 32'd0);
        read_valid = 1'b0;
        waited = 0;
        while (res_valid !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("bp0 full while stalled", 32'(read_ready), 32'd0);
        take_result("bp0", 4'd0, ST_TMO, 8'hFF, 3);
        for (int i = 1; i < 5; i++) begin
            serve($sformatf("bp%0d", i), bp_reads[i], 4'(i), -1, rand_lat(), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 254)), rand_lat(), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 254)), int'($urandom_range(0, 2)));
        end
        check("bp drained busy", 32'(busy), 32'd0);

        // Reset while the first of three reads is waiting on the engine.
        do_reset();
        push("rst a", 20'($urandom));
        push("rst b", 20'($urandom));
        push("rst c", 20'($urandom));
        check("rst in flight busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("mid-wait reset");
        reset     = 1'b0;
        eng_done  = 1'b1;
        eng_found = 1'b1;
        eng_index = 8'd9;
        @(negedge clk);
        eng_done  = 1'b0;
        eng_found = 1'b0;
        eng_index = '0;
        for (int k = 0; k < 4; k++) begin
            check("stale done res_valid", 32'(res_valid), 32'd0);
            check("stale done busy", 32'(busy), 32'd0);
            @(negedge clk);
        end
        rd = 20'($urandom);
        push("fresh", rd);
        serve("fresh", rd, 4'd0, 1, 2, 1'b1, 8'd33, 0, 1'b0, 8'd0, 0);

        // Randomized run of 17 reads; the sequence tag wraps from 15 back to 0.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            rd = 20'($urandom);
            push($sformatf("wrap%0d", i), rd);
            serve($sformatf("wrap%0d", i), rd, 4'(i), 1, rand_lat(), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 254)), rand_lat(), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 254)), int'($urandom_range(0, 2)));
            check($sformatf("wrap%0d busy", i), 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
